// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer and HI/LO owner: computes the result at start, holds
// the unit busy for a fixed per-op latency, then commits the result to HI/LO.
//
// state | meaning
// IDLE  | unit free; accepts start, mthi/mtlo
// RUN   | mult/div in flight; cnt counts down to commit
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [1:0]  E_md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        E_hilowe,
  input  logic        E_hilo_A3,
  input  logic [1:0]  E_re_hi_loop,
  input  logic        D_md_use,
  output logic        md_busy,
  output logic        md_stall,
  output logic [31:0] md_rdata,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_valid;

  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [31:0]      divisor;
  logic [31:0]      quot_s;
  logic [31:0]      rem_s;
  logic [31:0]      quot_u;
  logic [31:0]      rem_u;
  logic [31:0]      nxt_hi;
  logic [31:0]      nxt_lo;
  logic             nxt_valid;
  logic             is_div;

  // Divisor forced non-zero so the divider never produces X; the result is discarded anyway.
  assign divisor = (E_rt == 32'd0) ? 32'd1 : E_rt;
  assign prod_s  = $signed({{32{E_rs[31]}}, E_rs}) * $signed({{32{E_rt[31]}}, E_rt});
  assign prod_u  = {32'd0, E_rs} * {32'd0, E_rt};
  assign quot_s  = $signed(E_rs) / $signed(divisor);
  assign rem_s   = $signed(E_rs) % $signed(divisor);
  assign quot_u  = E_rs / divisor;
  assign rem_u   = E_rs % divisor;
  assign is_div  = E_md_op[1];

  always_comb begin
    nxt_hi    = 32'd0;
    nxt_lo    = 32'd0;
    nxt_valid = 1'b1;
    case (E_md_op)
      2'd0: {nxt_hi, nxt_lo} = prod_s;
      2'd1: {nxt_hi, nxt_lo} = prod_u;
      2'd2: begin
        nxt_hi    = rem_s;
        nxt_lo    = quot_s;
        nxt_valid = (E_rt != 32'd0);
      end
      default: begin
        nxt_hi    = rem_u;
        nxt_lo    = quot_u;
        nxt_valid = (E_rt != 32'd0);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      res_hi    <= 32'd0;
      res_lo    <= 32'd0;
      res_valid <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
      md_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (E_start) begin
            res_hi    <= nxt_hi;
            res_lo    <= nxt_lo;
            res_valid <= nxt_valid;
            cnt       <= is_div ? DIV_LOAD : MULT_LOAD;
            state     <= RUN;
            md_busy   <= 1'b1;
          end else if (E_hilowe) begin
            if (E_hilo_A3) HI <= E_rs;
            else           LO <= E_rs;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (res_valid) begin
              HI <= res_hi;
              LO <= res_lo;
            end
            state   <= IDLE;
            md_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    md_rdata = 32'd0;
    case (E_re_hi_loop)
      2'd1:    md_rdata = LO;
      2'd2:    md_rdata = HI;
      default: md_rdata = 32'd0;
    endcase
  end

  assign md_stall = D_md_use & (E_start | md_busy);

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
Multiply/divide sequencer and HI/LO register owner for the 5-stage MIPS pipeline.
- Accepts a one-cycle start pulse and operands from the E stage.
- Models a multi-cycle mult/div latency with a busy counter, then commits the result to HI/LO.
- Serves mthi/mtlo writes and mfhi/mflo reads.
- Raises a stall request toward the hazard unit when a D-stage instruction needs the unit while it is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
E_start  in  1  one-cycle pulse: E-stage instruction is mult/multu/div/divu
E_md_op  in  2  0=mult, 1=multu, 2=div, 3=divu; sampled with E_start
E_rs  in  32  forwarded rs operand (dividend / multiplicand)
E_rt  in  32  forwarded rt operand (divisor / multiplier)
E_hilowe  in  1  mthi/mtlo write enable
E_hilo_A3  in  1  write target: 0=LO, 1=HI
E_re_hi_loop  in  2  read select: 0=none, 1=LO, 2=HI, 3=none
D_md_use  in  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
md_busy  out  1  unit occupied
md_stall  out  1  stall request to hazard unit
md_rdata  out  32  mfhi/mflo read data
HI  out  32  HI register
LO  out  32  LO register

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, HI=0, LO=0, md_busy=0, md_stall=0, md_rdata=0. Result and operand latches are cleared.
- States:
  - IDLE: entered on reset or on completion.
  - RUN: a mult or div is in flight.
- IDLE -> RUN: on a clk edge with E_start=1.
  - Compute the 64-bit result from E_rs/E_rt/E_md_op into a result latch.
  - Load cnt = MULT_CYCLES-1 (op 0/1) or DIV_CYCLES-1 (op 2/3).
- RUN:
  - Each edge with cnt != 0 decrements cnt.
  - The edge with cnt == 0 writes HI/LO from the result latch and returns to IDLE.
- Latency: with start sampled at edge 0 and N cycles:
  - md_busy=1 for exactly N cycles after edge 0.
  - The new HI/LO are visible in the first cycle with md_busy=0.
- md_busy = (state==RUN); it is registered.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: the same, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (E_rt==0): full busy period, then HI/LO are left unchanged; no fault.
- mthi/mtlo:
  - E_hilowe=1 in IDLE with no E_start: write E_rs into HI (E_hilo_A3=1) or LO (E_hilo_A3=0) at the edge.
  - E_hilowe while md_busy=1 is ignored.
  - E_hilowe together with E_start: start wins and the write is dropped.
- E_start while md_busy=1 is ignored; the stall logic prevents it.
- md_rdata (combinational): LO when E_re_hi_loop=1, HI when 2, otherwise 0. It reflects the current registers with no bypass of in-flight results.
- md_stall (combinational) = D_md_use & (E_start | md_busy).
- Pipeline flush/clr of the E register does not cancel an in-flight operation.
- Reset mid-operation: aborts immediately; HI=LO=0, IDLE.

Test Plan:
- Reset, then E_start mult with rs=0xFFFFFFFF, rt=0x00000002 -> md_busy high cycles 1-5; HI=0xFFFFFFFF, LO=0xFFFFFFFE at cycle 6.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div rs=0xFFFFFFF9 (-7), rt=2 -> 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu rs=7, rt=2 -> LO=3, HI=1.
- Preload HI=0x12345678 and LO=0x9ABCDEF0 via mthi/mtlo; div with rt=0 -> busy 10 cycles, HI/LO unchanged; md_rdata=0x9ABCDEF0 with E_re_hi_loop=1 and 0x12345678 with 2.
- D_md_use=1 held during start and busy -> md_stall=1 from the start cycle through the last busy cycle, 0 after. E_hilowe pulse during busy -> HI/LO unchanged.
- Assert reset asynchronously at busy cycle 3 of a mult -> md_busy, HI, LO drop to 0 before the next edge; a fresh start after release completes normally.
